// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage operand forwarding and load-use interlock with per-register countdown scoreboard
// Ports: clk/rst (async active-low); id_* describe the instruction in ID; ex_ready advances the pipe;
// flush squashes ID; fwd_* are forwarding sources (index 0 youngest, highest priority);
// op_data resolved operands, issue/stallreq handshake, busy_map pending loads, stall_cycles saturating count.
module id_hazard_ctrl #(
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NFWD = 3,
  parameter int LOAD_LAT = 1,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(LOAD_LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*AW-1:0]     id_raddr,
  input  logic [NSRC-1:0]        id_ruse,
  input  logic [NSRC*DATA_W-1:0] id_rf_rdata,
  input  logic                   id_we,
  input  logic [AW-1:0]          id_waddr,
  input  logic                   id_is_load,
  input  logic                   ex_ready,
  input  logic                   flush,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD*AW-1:0]     fwd_waddr,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata,
  output logic [NSRC*DATA_W-1:0] op_data,
  output logic                   issue,
  output logic                   stallreq,
  output logic [NREG-1:0]        busy_map,
  output logic [15:0]            stall_cycles
);
  logic [CW-1:0] cnt [NREG];
  logic hz, hazard, load_set;
  always_comb begin
    op_data = id_rf_rdata;
    for (int k = 0; k < NSRC; k++) begin
      // scan oldest to youngest so the lowest index wins
      for (int i = NFWD - 1; i >= 0; i--)
        if (fwd_we[i] && fwd_waddr[i*AW +: AW] == id_raddr[k*AW +: AW])
          op_data[k*DATA_W +: DATA_W] = fwd_wdata[i*DATA_W +: DATA_W];
      if (id_raddr[k*AW +: AW] == '0) op_data[k*DATA_W +: DATA_W] = '0;
    end
  end
  always_comb begin
    busy_map = '0;
    for (int r = 1; r < NREG; r++) busy_map[r] = cnt[r] != '0;
  end
  always_comb begin
    hz = 1'b0;
    for (int k = 0; k < NSRC; k++) hz = hz | (id_ruse[k] & busy_map[id_raddr[k*AW +: AW]]);
  end
  assign hazard = id_valid & ~flush & hz;
  assign stallreq = hazard;
  assign issue = id_valid & ex_ready & ~flush & ~hazard;
  assign load_set = issue & id_we & id_is_load;
  assign cnt[0] = '0;
  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_cnt
      always_ff @(posedge clk or negedge rst)
        if (!rst) cnt[r] <= '0;
        else if (load_set && id_waddr == AW'(r)) cnt[r] <= CW'(LOAD_LAT);
        else if (ex_ready && cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
    end
  endgenerate
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cycles <= '0;
    else if (stallreq && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
endmodule
